// File: rtl/reduce_unit_seq.sv
// Multi-cycle bit-reduction unit: zero / all-ones / parity / leading-zero count.
// Scans the latched operand CHUNK bits per clock, MSB chunk first, valid/ready on both sides.
module reduce_unit_seq #(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [1:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             result_flag_o,
  output logic [CW-1:0]    result_cnt_o,
  output logic             busy_o
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       mode_q, mode_d;
  logic [KW-1:0]    k_q, k_d;
  logic             or_q, or_d, and_q, and_d, xor_q, xor_d, seen_q, seen_d;
  logic [CW-1:0]    lz_q, lz_d;
  logic             flag_q, flag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK-1:0] chunk;

  // Operand is shifted left each RUN cycle, so the current chunk is always the top slice.
  assign chunk = a_q[WIDTH-1 -: CHUNK];

  function automatic logic [CW-1:0] clz(input logic [CHUNK-1:0] c);
    clz = CW'(CHUNK);
    for (int i = 0; i < CHUNK; i++)
      if (c[i]) clz = CW'(CHUNK - 1 - i);
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mode_d  = mode_q;
    k_d     = k_q;
    or_d    = or_q;
    and_d   = and_q;
    xor_d   = xor_q;
    seen_d  = seen_q;
    lz_d    = lz_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        a_d     = in_a_i;
        mode_d  = in_mode_i;
        k_d     = '0;
        or_d    = 1'b0;
        and_d   = 1'b1;
        xor_d   = 1'b0;
        seen_d  = 1'b0;
        lz_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d   = a_q << CHUNK;
        k_d   = k_q + KW'(1);
        or_d  = or_q | (|chunk);
        and_d = and_q & (&chunk);
        xor_d = xor_q ^ (^chunk);
        if (!seen_q) begin
          lz_d   = lz_q + clz(chunk);
          seen_d = |chunk;
        end
        if (k_q == KW'(N-1)) begin
          state_d = DONE;
          cnt_d   = '0;
          case (mode_q)
            2'b00: flag_d = ~or_d;
            2'b01: flag_d = and_d;
            2'b10: flag_d = xor_d;
            default: begin
              flag_d = (lz_d == CW'(WIDTH));
              cnt_d  = lz_d;
            end
          endcase
        end
      end
      DONE: if (out_ready_i) begin
        state_d = IDLE;
        flag_d  = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // Abort beats any same-cycle accept or result handshake.
    if (flush_i) begin
      state_d = IDLE;
      flag_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      mode_q  <= '0;
      k_q     <= '0;
      or_q    <= 1'b0;
      and_q   <= 1'b1;
      xor_q   <= 1'b0;
      seen_q  <= 1'b0;
      lz_q    <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      or_q    <= or_d;
      and_q   <= and_d;
      xor_q   <= xor_d;
      seen_q  <= seen_d;
      lz_q    <= lz_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o    = (state_q == IDLE);
  assign out_valid_o   = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign result_flag_o = flag_q;
  assign result_cnt_o  = cnt_q;
endmodule

// File: tb/tb_reduce_unit_seq.sv
// Directed bench for reduce_unit_seq at WIDTH=32, CHUNK=8 (4 RUN cycles per operation).
module tb_reduce_unit_seq;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int CW    = $clog2(WIDTH+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             result_flag;
  logic [CW-1:0]    result_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  reduce_unit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_mode_i    (in_mode),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .result_flag_o(result_flag),
    .result_cnt_o (result_cnt),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, check exact 4-edge latency and the result, then hand it off.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [1:0] mode,
                        input logic exp_flag, input logic [CW-1:0] exp_cnt);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_mode = mode; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = ~a;
    in_mode = ~mode;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk({tag, "_vld_low"}, 32'(out_valid), 32'd0);
      step();
    end
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_flag"}, 32'(result_flag), 32'(exp_flag));
    chk({tag, "_cnt"}, 32'(result_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flag", 32'(result_flag), 32'd0);
    chk("rst_cnt", 32'(result_cnt), 32'd0);
    #10 rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // zero detect, all-ones, parity, leading-zero count
    run_op("t1_zero",    32'h0000_0000, 2'b00, 1'b1, 6'd0);
    run_op("t1_nonzero", 32'h0000_0100, 2'b00, 1'b0, 6'd0);
    run_op("t2_ones",    32'hFFFF_FFFF, 2'b01, 1'b1, 6'd0);
    run_op("t2_notones", 32'hFFFF_FFFE, 2'b01, 1'b0, 6'd0);
    run_op("t3_even",    32'h8000_0001, 2'b10, 1'b0, 6'd0);
    run_op("t3_odd",     32'h0000_0007, 2'b10, 1'b1, 6'd0);
    run_op("t4_lz15",    32'h0001_0000, 2'b11, 1'b0, 6'd15);
    run_op("t4_lz0",     32'h8000_0000, 2'b11, 1'b0, 6'd0);
    run_op("t4_lz32",    32'h0000_0000, 2'b11, 1'b1, 6'd32);
    run_op("t4_lz31",    32'h0000_0001, 2'b11, 1'b0, 6'd31);

    // backpressure in DONE with a competing operand offered
    in_a = 32'h0000_0007; in_mode = 2'b10; in_valid = 1'b1;
    step();
    in_a = 32'h0000_0000; in_mode = 2'b00;
    repeat (4) step();
    chk("t5_vld", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_vld", 32'(out_valid), 32'd1);
      chk("t5_hold_flag", 32'(result_flag), 32'd1);
      chk("t5_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t5_hold_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_release_vld", 32'(out_valid), 32'd0);
    chk("t5_release_in_ready", 32'(in_ready), 32'd1);
    chk("t5_release_busy", 32'(busy), 32'd0);

    // flush in the second RUN cycle
    in_a = 32'h0000_0000; in_mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_busy", 32'(busy), 32'd0);
    chk("t6_flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("t6_flush_no_vld", 32'(out_valid), 32'd0);
      step();
    end

    // flush beats a simultaneous accept
    flush = 1'b1; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_flush_vs_accept", 32'(busy), 32'd0);

    // flush beats a simultaneous output handshake; result is cleared too
    in_a = 32'hFFFF_FFFF; in_mode = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("t6_done_flag", 32'(result_flag), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    chk("t6_flush_done_vld", 32'(out_valid), 32'd0);
    chk("t6_flush_done_flag", 32'(result_flag), 32'd0);

    // async reset mid-RUN
    in_a = 32'h0000_0000; in_mode = 2'b11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_vld", 32'(out_valid), 32'd0);
    chk("t6_rst_cnt", 32'(result_cnt), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_rst_no_vld", 32'(out_valid), 32'd0);
    end
    run_op("t6_after_rst", 32'h00F0_0000, 2'b11, 1'b0, 6'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
